// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: memory widths, csel encodings and the
// flatten_l2 state encoding.
package cnn_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int N_PIX  = 1024;
  localparam int IDX_W  = 10;

  localparam logic [2:0] CSEL_L0_K0 = 3'b001;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2    = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR1  = 3'd4,
    S_FIN  = 3'd5
  } flat_state_t;

endpackage

// File: rtl/flatten_l2_if.sv
// Shared cdata memory port: one read channel, one write channel, and a
// select that qualifies whichever strobe is active.
interface flatten_l2_if;
  import cnn_pkg::*;

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/flatten_l2.sv
// Layer-2 flatten: copies layer-1 channels K0/K1 into one interleaved L2
// vector, L2[2i]=K0[i], L2[2i+1]=K1[i], one element pair every 4 cycles.
module flatten_l2
  import cnn_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output flat_state_t  dbg_state,
  flatten_l2_if.master mem
);

  // Control handshake: start is a level sampled only in S_IDLE (never
  // queued); busy is high from the first read cycle through the last write
  // cycle; done pulses for exactly one cycle once the final element is written.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  flat_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  logic              crd_q, crd_d;
  logic              cwr_q, cwr_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic [2:0]        csel_q, csel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cap_q      <= '0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      csel_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      csel_q     <= csel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    csel_d     = csel_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_RD0;
      S_RD0: begin
        cap_d   = mem.cdata_rd;
        state_d = S_WR0;
      end
      S_WR0: state_d = S_RD1;
      S_RD1: begin
        cap_d   = mem.cdata_rd;
        state_d = S_WR1;
      end
      S_WR1: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD0;
        end
      end
      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered; csel therefore only moves on the edge that raises its strobe.
    case (state_d)
      S_RD0: begin
        crd_d      = 1'b1;
        csel_d     = CSEL_L1_K0;
        caddr_rd_d = {2'b00, idx_d};
        busy_d     = 1'b1;
      end
      S_WR0: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L2;
        caddr_wr_d = {1'b0, idx_d, 1'b0};
        busy_d     = 1'b1;
      end
      S_RD1: begin
        crd_d      = 1'b1;
        csel_d     = CSEL_L1_K1;
        caddr_rd_d = {2'b00, idx_d};
        busy_d     = 1'b1;
      end
      S_WR1: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L2;
        caddr_wr_d = {1'b0, idx_d, 1'b1};
        busy_d     = 1'b1;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign mem.crd      = crd_q;
  assign mem.cwr      = cwr_q;
  assign mem.caddr_rd = caddr_rd_q;
  assign mem.caddr_wr = caddr_wr_q;
  assign mem.cdata_wr = cap_q;
  assign mem.csel     = csel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule
